// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus between fetch_sequencer (master) and the ROM (slave).
// The ROM answers a held request by raising imem_ready with data on instr_in.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ready;
    logic [31:0]       instr_in;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ready,
        input  instr_in
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ready,
        output instr_in
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch / next-PC sequencer: IDLE -> REQ -> ISSUE handshake with any-latency ROM.
// Define FETCH_RAS_EN to build the hardware return-address stack (ret honoured, jal pushes).
module fetch_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int RESET_PC  = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  imem,
    output logic [31:0]        instr_out,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [15:0]        branch_offset,
    input  logic               jump,
    input  logic               jal,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               jr,
    input  logic [31:0]        jr_target,
    input  logic               ret,
    output logic [ADDR_W-1:0]  link_addr,
    output logic [31:0]        instr_count,
    output logic               ras_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       count_q, count_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] pc_plus1;
    logic [31:0]       offset_ext;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              advance;

    assign pc_plus1   = pc_q + ADDR_W'(1);
    assign offset_ext = {{16{branch_offset[15]}}, branch_offset};
    assign branch_pc  = pc_plus1 + offset_ext[ADDR_W-1:0];
    assign advance    = (state_q == ISSUE) && !stall;

    // Upper operand bits never reach the address space.
    logic unused_upper_bits;
    assign unused_upper_bits = ^{jr_target[31:ADDR_W], offset_ext[31:ADDR_W]};

`ifdef FETCH_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;
    logic [PTR_W:0]    ras_cnt_q, ras_cnt_d;
    logic              ras_uf_q, ras_uf_d;
    logic [PTR_W-1:0]  ras_top_idx;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push, ras_pop, ras_uf_set;

    // ras_ptr points at the next free slot; wrapping it makes a full push overwrite the oldest entry.
    assign ras_top_idx = ras_ptr_q - PTR_W'(1);
    assign ras_top     = ras_mem[ras_top_idx];
`endif

    always_comb begin
        next_pc = pc_plus1;
`ifdef FETCH_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_uf_set = 1'b0;
`endif
        if (jr) begin
            next_pc = jr_target[ADDR_W-1:0];
        end
`ifdef FETCH_RAS_EN
        else if (ret) begin
            if (ras_cnt_q != '0) begin
                next_pc = ras_top;
                ras_pop = 1'b1;
            end else begin
                ras_uf_set = 1'b1;
            end
        end
`endif
        else if (jal) begin
            next_pc = jump_target;
`ifdef FETCH_RAS_EN
            ras_push = 1'b1;
`endif
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem.imem_ready) begin
                    instr_d = imem.instr_in;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake outputs are registered from the next state so they are glitch-free.
        req_d   = (state_d == REQ);
        valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            instr_q <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_RAS_EN
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_uf_d  = ras_uf_q;
        if (advance) begin
            if (ras_push) begin
                ras_ptr_d = ras_ptr_q + PTR_W'(1);
                if (ras_cnt_q != RAS_FULL) begin
                    ras_cnt_d = ras_cnt_q + (PTR_W + 1)'(1);
                end
            end else if (ras_pop) begin
                ras_ptr_d = ras_top_idx;
                ras_cnt_d = ras_cnt_q - (PTR_W + 1)'(1);
            end
            if (ras_uf_set) begin
                ras_uf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            ras_uf_q  <= 1'b0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            ras_uf_q  <= ras_uf_d;
        end
    end

    // Stack storage needs no reset: entries are only read when ras_cnt_q says they were written.
    always_ff @(posedge clk) begin
        if (advance && ras_push) begin
            ras_mem[ras_ptr_q] <= pc_plus1;
        end
    end

    assign ras_underflow = ras_uf_q;
`else
    logic unused_ret;
    assign unused_ret    = ret;
    assign ras_underflow = 1'b0;
`endif

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req_q;
    assign instr_out      = instr_q;
    assign instr_valid    = valid_q;
    assign instr_count    = count_q;
    assign link_addr      = pc_plus1;

endmodule
